// File: rtl/cbc_stream_harness.sv
// cbc_stream_harness: stimulus player and result capture for control-bounded
// filter cores. A preloaded N-bit control sequence is replayed (looping over
// the sample memory) for TEST_LEN cycles. DUT results are then captured for
// DRAIN_CYC more cycles into a first-word-fall-through FIFO. The valid cadence
// of those results is checked against DSR.
// Optional build macro: CBC_HARNESS_CHECKSUM_EN adds a rolling checksum output.
module cbc_stream_harness #(
   parameter int N         = 4,
   parameter int OUT_W     = 32,
   parameter int DSR       = 1,
   parameter int MEM_DEPTH = 1024,
   parameter int CAP_DEPTH = 256,
   parameter int TEST_LEN  = 24000,
   parameter int DRAIN_CYC = 512
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ld_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
   input  logic [N-1:0]                 ld_data,
   input  logic                         start,
   output logic [N-1:0]                 sample,
   output logic                         sample_valid,
   input  logic [OUT_W-1:0]             res,
   input  logic                         res_valid,
   input  logic                         rd_en,
   output logic [OUT_W-1:0]             rd_data,
   output logic                         rd_valid,
   output logic                         busy,
   output logic                         done,
`ifdef CBC_HARNESS_CHECKSUM_EN
   output logic [OUT_W-1:0]             checksum,
`endif
   output logic [15:0]                  overflow_cnt,
   output logic                         cadence_err
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CW = $clog2(TEST_LEN + 1);
   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam int PW = $clog2(CAP_DEPTH);
   localparam int GW = $clog2(DSR + 2);

   localparam logic [CW-1:0] TEST_LEN_C  = CW'(TEST_LEN);
   localparam logic [DW-1:0] DRAIN_END_C = DW'(DRAIN_CYC - 1);
   localparam logic [GW-1:0] DSR_C       = GW'(DSR);
   localparam logic [GW-1:0] GAP_MAX_C   = {GW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Rotate left by one bit; used by the optional result checksum.
   function automatic logic [OUT_W-1:0] rotl1(input logic [OUT_W-1:0] x);
      return {x[OUT_W-2:0], x[OUT_W-1]};
   endfunction

   state_t            state_r, state_next_s;
   logic              busy_r, done_r;
   logic [N-1:0]      smp_mem_r [MEM_DEPTH];
   logic [N-1:0]      sample_r;
   logic              sample_valid_r;
   logic [CW-1:0]     smp_cnt_r;
   logic [AW-1:0]     rd_addr_r;
   logic [DW-1:0]     drain_cnt_r;
   logic [OUT_W-1:0]  cap_mem_r [CAP_DEPTH];
   logic [PW:0]       wr_ptr_r, rd_ptr_r;
   logic [15:0]       overflow_r;
   logic              cadence_err_r;
   logic              armed_r;
   logic [GW-1:0]     gap_r;
   logic              start_acc_s, acc_s, empty_s, full_s, pop_s, push_s;

   assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign acc_s       = res_valid && busy_r;
   assign empty_s     = (wr_ptr_r == rd_ptr_r);
   assign full_s      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                        (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
   assign pop_s       = rd_en && !empty_s;
   assign push_s      = acc_s && (!full_s || pop_s);

   // Next-state logic of the run sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = state_r;
         end
         ST_RUN: begin
            if (smp_cnt_r == TEST_LEN_C) state_next_s = ST_DRAIN;
            else                         state_next_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (drain_cnt_r == DRAIN_END_C) state_next_s = ST_DONE;
            else                            state_next_s = ST_DRAIN;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register with busy/done decoded from the next state so they are flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
         done_r  <= (state_next_s == ST_DONE);
      end
   end

   // Drain timer: counts cycles spent in DRAIN, held at zero elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      drain_cnt_r <= {DW{1'b0}};
      else if (state_r == ST_DRAIN) drain_cnt_r <= drain_cnt_r + DW'(1);
      else                          drain_cnt_r <= {DW{1'b0}};
   end

   // Sample memory write port; loads are locked out while a run is active.
   always_ff @(posedge clk) begin
      if (ld_we && !busy_r) smp_mem_r[ld_addr] <= ld_data;
   end

   // Playback: registered memory read; the first sample issues on start acceptance
   // so the counter holds the number of samples already issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_r       <= {N{1'b0}};
         sample_valid_r <= 1'b0;
         smp_cnt_r      <= {CW{1'b0}};
         rd_addr_r      <= {AW{1'b0}};
      end else if (start_acc_s) begin
         sample_r       <= smp_mem_r[{AW{1'b0}}];
         sample_valid_r <= 1'b1;
         smp_cnt_r      <= CW'(1);
         rd_addr_r      <= AW'(1);
      end else if ((state_r == ST_RUN) && (smp_cnt_r != TEST_LEN_C)) begin
         sample_r       <= smp_mem_r[rd_addr_r];
         sample_valid_r <= 1'b1;
         smp_cnt_r      <= smp_cnt_r + CW'(1);
         rd_addr_r      <= rd_addr_r + AW'(1);
      end else begin
         sample_r       <= {N{1'b0}};
         sample_valid_r <= 1'b0;
      end
   end

   // Capture FIFO storage; a push into a full FIFO is only legal alongside a pop,
   // which has already consumed the slot being overwritten.
   always_ff @(posedge clk) begin
      if (push_s) cap_mem_r[wr_ptr_r[PW-1:0]] <= res;
   end

   // Capture FIFO pointers; only reset empties the FIFO, not start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(PW+1){1'b0}};
         rd_ptr_r <= {(PW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
      end
   end

   // Overflow counter: saturating count of results dropped on a full FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                overflow_r <= 16'h0000;
      else if (start_acc_s)                                   overflow_r <= 16'h0000;
      else if (acc_s && !push_s && (overflow_r != 16'hFFFF))  overflow_r <= overflow_r + 16'h0001;
      else                                                    overflow_r <= overflow_r;
   end

   // Cadence tracker: gap counts cycles since the previous result; first result only arms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cadence_err_r <= 1'b0;
         armed_r       <= 1'b0;
         gap_r         <= {GW{1'b0}};
      end else if (start_acc_s) begin
         cadence_err_r <= 1'b0;
         armed_r       <= 1'b0;
         gap_r         <= {GW{1'b0}};
      end else if (acc_s) begin
         if (armed_r && (gap_r != DSR_C)) cadence_err_r <= 1'b1;
         armed_r <= 1'b1;
         gap_r   <= GW'(1);
      end else if (gap_r != GAP_MAX_C) begin
         gap_r <= gap_r + GW'(1);
      end
   end

`ifdef CBC_HARNESS_CHECKSUM_EN
   logic [OUT_W-1:0] checksum_r;

   // Rolling checksum over every result accepted into the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              checksum_r <= {OUT_W{1'b0}};
      else if (start_acc_s) checksum_r <= {OUT_W{1'b0}};
      else if (push_s)      checksum_r <= rotl1(checksum_r) ^ res;
      else                  checksum_r <= checksum_r;
   end

   assign checksum = checksum_r;
`endif

   assign sample       = sample_r;
   assign sample_valid = sample_valid_r;
   assign rd_data      = cap_mem_r[rd_ptr_r[PW-1:0]];
   assign rd_valid     = !empty_s;
   assign busy         = busy_r;
   assign done         = done_r;
   assign overflow_cnt = overflow_r;
   assign cadence_err  = cadence_err_r;

endmodule

// File: tb/tb_cbc_stream_harness.sv
// Directed self-checking bench for cbc_stream_harness with small parameters:
// MEM_DEPTH=4, TEST_LEN=10, DSR=4, CAP_DEPTH=4, OUT_W=8, DRAIN_CYC=30.
module tb_cbc_stream_harness;

   localparam int DRAIN_CYC = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld_we = 1'b0;
   logic [1:0] ld_addr = 2'd0;
   logic [3:0] ld_data = 4'd0;
   logic       start = 1'b0;
   logic [3:0] sample;
   logic       sample_valid;
   logic [7:0] res = 8'd0;
   logic       res_valid = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic       done;
   logic [15:0] overflow_cnt;
   logic       cadence_err;
`ifdef CBC_HARNESS_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   int total = 0;
   int bad   = 0;

   cbc_stream_harness #(
      .N(4), .OUT_W(8), .DSR(4), .MEM_DEPTH(4), .CAP_DEPTH(4),
      .TEST_LEN(10), .DRAIN_CYC(DRAIN_CYC)
   ) dut (
      .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .sample(sample), .sample_valid(sample_valid),
      .res(res), .res_valid(res_valid), .rd_en(rd_en), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .done(done),
`ifdef CBC_HARNESS_CHECKSUM_EN
      .checksum(checksum),
`endif
      .overflow_cnt(overflow_cnt), .cadence_err(cadence_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   // Push one result, pop it the next cycle, then idle; gap to next push = 2 + idle.
   task automatic push_pop(input logic [7:0] v, input int idle);
      res = v; res_valid = 1'b1;
      tick;
      res_valid = 1'b0;
      chk("fifo_head", {24'd0, rd_data}, {24'd0, v});
      rd_en = 1'b1;
      tick;
      rd_en = 1'b0;
      chk("fifo_empty", {31'd0, rd_valid}, 32'd0);
      repeat (idle) tick;
   endtask

   // Push one result with no pop; gap to next push = 4.
   task automatic push_only(input logic [7:0] v);
      res = v; res_valid = 1'b1;
      tick;
      res_valid = 1'b0;
      repeat (3) tick;
   endtask

   task automatic wait_done;
      int n;
      n = 0;
      while (!done && n < 200) begin
         tick;
         n++;
      end
      chk("wait_done", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [3:0] seq [4];
      logic [7:0] pop_exp [4];
      seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd4; seq[3] = 4'd8;

      // Reset values
      #1;
      chk("rst_sample",   {28'd0, sample}, 32'd0);
      chk("rst_svalid",   {31'd0, sample_valid}, 32'd0);
      chk("rst_busy",     {31'd0, busy}, 32'd0);
      chk("rst_done",     {31'd0, done}, 32'd0);
      chk("rst_ovf",      {16'd0, overflow_cnt}, 32'd0);
      chk("rst_cadence",  {31'd0, cadence_err}, 32'd0);
      chk("rst_rdvalid",  {31'd0, rd_valid}, 32'd0);
      tick;
      rst = 1'b0;
      tick;

      // Load the sample memory
      for (int i = 0; i < 4; i++) begin
         ld_we = 1'b1; ld_addr = 2'(i); ld_data = seq[i];
         tick;
      end
      ld_we = 1'b0;

      // Run 1: playback sequence loops over memory; a start mid-run is ignored
      start_run;
      for (int k = 0; k < 10; k++) begin
         chk("play_valid", {31'd0, sample_valid}, 32'd1);
         chk("play_sample", {28'd0, sample}, {28'd0, seq[k % 4]});
         start = (k == 5);
         tick;
      end
      start = 1'b0;
      chk("play_end_valid", {31'd0, sample_valid}, 32'd0);
      chk("play_end_sample", {28'd0, sample}, 32'd0);
      chk("drain_busy", {31'd0, busy}, 32'd1);
      repeat (DRAIN_CYC - 1) tick;
      chk("drain_not_done", {31'd0, done}, 32'd0);
      tick;
      chk("done_set", {31'd0, done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd0);

      // Run 2: cadence of 4 is clean, then a gap of 3 sets the sticky error
      start_run;
      push_pop(8'h11, 2);
      push_pop(8'h22, 2);
      push_pop(8'h33, 1);
      chk("cadence_ok", {31'd0, cadence_err}, 32'd0);
      push_pop(8'h44, 0);
      chk("cadence_bad", {31'd0, cadence_err}, 32'd1);
      wait_done;
      chk("cadence_sticky", {31'd0, cadence_err}, 32'd1);

      // Run 3: overflow with no reads, then simultaneous push/pop on full
      start_run;
      chk("cadence_cleared", {31'd0, cadence_err}, 32'd0);
      for (int i = 0; i < 6; i++) push_only(8'hA0 + 8'(i));
      chk("ovf_rdvalid", {31'd0, rd_valid}, 32'd1);
      chk("ovf_count", {16'd0, overflow_cnt}, 32'd2);
      chk("ovf_head", {24'd0, rd_data}, 32'h0000_00A0);
      res = 8'hB0; res_valid = 1'b1; rd_en = 1'b1;
      tick;
      res_valid = 1'b0; rd_en = 1'b0;
      chk("full_pushpop_ovf", {16'd0, overflow_cnt}, 32'd2);
      pop_exp[0] = 8'hA1; pop_exp[1] = 8'hA2; pop_exp[2] = 8'hA3; pop_exp[3] = 8'hB0;
      for (int i = 0; i < 4; i++) begin
         chk("pop_data", {24'd0, rd_data}, {24'd0, pop_exp[i]});
         rd_en = 1'b1;
         tick;
         rd_en = 1'b0;
      end
      chk("pop_empty", {31'd0, rd_valid}, 32'd0);
      rd_en = 1'b1;
      tick;
      rd_en = 1'b0;
      chk("pop_while_empty", {31'd0, rd_valid}, 32'd0);
      wait_done;

      // Run 4: asynchronous reset mid-run, then replay from mem[0]
      start_run;
      res = 8'h5A; res_valid = 1'b1;
      tick;
      res_valid = 1'b0;
      tick;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_svalid", {31'd0, sample_valid}, 32'd0);
      chk("arst_sample", {28'd0, sample}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_rdvalid", {31'd0, rd_valid}, 32'd0);
      #1 rst = 1'b0;
      tick;
      start_run;
      chk("replay_s0", {28'd0, sample}, 32'd1);
      tick;
      chk("replay_s1", {28'd0, sample}, 32'd2);
      wait_done;

`ifdef CBC_HARNESS_CHECKSUM_EN
      // Run 5: checksum 0x00 -> 0x01 -> 0x00
      start_run;
      chk("csum_clear", {24'd0, checksum}, 32'd0);
      push_only(8'h01);
      chk("csum_first", {24'd0, checksum}, 32'd1);
      push_only(8'h02);
      chk("csum_second", {24'd0, checksum}, 32'd0);
      wait_done;
      chk("csum_done", {24'd0, checksum}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cbc_stream_harness.md
Name: cbc_stream_harness

Overview:
- Synthesizable stimulus player and result capture unit for control-bounded filter cores (FIR, IIR, hybrid) under test.
- Replays a preloaded N-bit control-signal sequence into the DUT and checks the DUT's valid cadence against DSR.
- Buffers DUT results in a capture FIFO for readout by a host or testbench.
- Generalises the fixed-length, single-DSR bench stimulus into a parametrised, run-time-controlled block that can be reused on FPGA.

Parameters:
- N, 4, control-signal bits per sample.
- OUT_W, 32, DUT result width.
- DSR, 1, expected downsampling ratio; valid gap in cycles; must be >= 1.
- MEM_DEPTH, 1024, sample memory entries; power of two.
- CAP_DEPTH, 256, capture FIFO entries; power of two.
- TEST_LEN, 24000, samples played per run.
- DRAIN_CYC, 512, cycles the unit keeps capturing after the last sample.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ld_we  in  1  sample memory write strobe.
- ld_addr  in  log2(MEM_DEPTH)  sample memory write address.
- ld_data  in  N  sample memory write data.
- start  in  1  single-cycle run request.
- sample  out  N  control sample to DUT.
- sample_valid  out  1  sample is live this cycle.
- res  in  OUT_W  DUT result.
- res_valid  in  1  DUT result strobe.
- rd_en  in  1  capture FIFO pop.
- rd_data  out  OUT_W  FIFO head.
- rd_valid  out  1  FIFO non-empty.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- overflow_cnt  out  16  dropped results; saturates at 0xFFFF.
- cadence_err  out  1  sticky; set on a valid gap != DSR.

Behaviour:
- Reset (async, rst=1): state IDLE; all counters and pointers 0; sample=0, sample_valid=0, busy=0, done=0, cadence_err=0, overflow_cnt=0, rd_valid=0. Sample memory contents are not reset.
- FSM:
  - IDLE/DONE: start=1 -> RUN. Entering RUN clears the sample counter, read address, overflow_cnt, cadence_err and the cadence tracker. The FIFO is not cleared.
  - RUN: start is ignored.
  - RUN -> DRAIN when the sample counter reaches TEST_LEN.
  - DRAIN -> DONE after DRAIN_CYC cycles.
  - DONE holds until the next start.
- Playback:
  - The memory read is registered. sample_valid goes high the cycle after start is accepted.
  - Exactly TEST_LEN consecutive valid samples are played.
  - Read address wraps modulo MEM_DEPTH, so the stored sequence loops.
  - sample=0 whenever sample_valid=0.
- Load port: ld_we is honoured only in IDLE/DONE and ignored while busy.
- Capture:
  - res_valid is accepted only while busy=1. It is pushed to the FIFO unless the FIFO is full, in which case the result is dropped and overflow_cnt increments.
  - Full with simultaneous pop and push: the pop frees an entry and the push is accepted, so nothing is dropped.
  - Pop while empty has no effect.
  - rd_data is first-word-fall-through (FWFT) and is valid when rd_valid=1.
- Cadence:
  - The first res_valid of a run arms the tracker; no check is made on it.
  - Each later res_valid is checked: if the cycles since the previous one != DSR, cadence_err is set.
  - cadence_err stays set until the next start.
- Reset mid-run aborts the run immediately and empties the FIFO.

Optional Feature:
- Macro: CBC_HARNESS_CHECKSUM_EN.
- Defined: adds output checksum [OUT_W].
  - Cleared at start.
  - Updated as checksum = rotl1(checksum) XOR res on every accepted push.
  - Stable once done=1.
- Undefined: no checksum port or logic; all other behaviour identical.

Test Plan:
- Load mem[0..3] = 1,2,4,8; MEM_DEPTH=4, TEST_LEN=10; start -> sample sequence 1,2,4,8,1,2,4,8,1,2 with sample_valid high for exactly 10 cycles; done after DRAIN_CYC.
- DSR=4; res_valid every 4 cycles -> cadence_err=0. Then one gap of 3 -> cadence_err=1, still 1 at done, cleared by the next start.
- CAP_DEPTH=4, no reads, 6 results pushed -> rd_valid=1, overflow_cnt=2, popped data equals the first 4 results in order.
- FIFO full with rd_en and res_valid in the same cycle -> overflow_cnt unchanged, new result appears last.
- Assert rst mid-RUN -> outputs return to reset values asynchronously; start afterwards replays from mem[0].
- With CBC_HARNESS_CHECKSUM_EN, results 0x1, 0x2 (OUT_W=8) -> checksum = 0x00 -> 0x01 -> (0x02 XOR 0x02) = 0x00 at done.
